inv_park_clark_tr: RTL and testbench

INV_PARK_CLARK_TR -- requirements
Module: inv_park_clark_tr

---
 rtl/inv_park_clark_tr.sv | 226 ++++++++++++++++++++++
 tb/tb_inv_park_clark_tr.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/inv_park_clark_tr.sv
// ============================================================================
//  Module      : inv_park_clark_tr (with sincos helper)
//  Description : Sequential inverse-Park followed by inverse-Clarke transform
//                on a single shared 16x16 signed multiplier.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

// Iterative CORDIC: sin/cos of a 12-bit angle, amplitude +/-16384.
module sincos (
  input  logic               clk,
  input  logic               rstn,
  input  logic               i_en,
  input  logic [11:0]        i_psi,
  output logic               o_en,
  output logic signed [15:0] o_sin,
  output logic signed [15:0] o_cos
);
  localparam logic signed [29:0] c_x_init  = 30'sd163008219;
  localparam logic [4:0]         c_last_it = 5'd25;

  logic signed [29:0] r_x, r_y;
  logic signed [31:0] r_z;
  logic [4:0]         r_it;
  logic [1:0]         r_q;
  logic               r_run, r_fin, r_oen;
  logic signed [15:0] r_sin, r_cos;
  logic signed [29:0] w_dx, w_dy;
  logic signed [15:0] w_c, w_s;
  logic signed [31:0] w_atan;

  // Angle unit: 2^32 per full turn; small angles use atan(x) ~ x.
  function automatic logic signed [31:0] atan_lut(input logic [4:0] i);
    case (i)
      5'd0:    atan_lut = 32'sh2000_0000;
      5'd1:    atan_lut = 32'sh12E4_051E;
      5'd2:    atan_lut = 32'sh09FB_385B;
      5'd3:    atan_lut = 32'sh0511_11D4;
      5'd4:    atan_lut = 32'sh028B_0D43;
      5'd5:    atan_lut = 32'sh0145_D7E1;
      5'd6:    atan_lut = 32'sh00A2_F61E;
      5'd7:    atan_lut = 32'sh0051_7C55;
      5'd8:    atan_lut = 32'sh0028_BE53;
      5'd9:    atan_lut = 32'sh0014_5F2F;
      default: atan_lut = 32'sd683565276 >>> i;
    endcase
  endfunction

  assign w_dx   = r_y >>> r_it;
  assign w_dy   = r_x >>> r_it;
  assign w_atan = atan_lut(r_it);
  assign w_c    = r_x[29:14] + {15'd0, r_x[13]};
  assign w_s    = r_y[29:14] + {15'd0, r_y[13]};
  assign o_en   = r_oen;
  assign o_sin  = r_sin;
  assign o_cos  = r_cos;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_x <= '0; r_y <= '0; r_z <= '0; r_it <= '0; r_q <= '0;
      r_run <= 1'b0; r_fin <= 1'b0; r_oen <= 1'b0;
      r_sin <= '0; r_cos <= '0;
    end else begin
      r_fin <= 1'b0;
      r_oen <= 1'b0;
      if (i_en && !r_run) begin
        r_x   <= c_x_init;
        r_y   <= '0;
        r_z   <= {2'b00, i_psi[9:0], 20'd0};
        r_q   <= i_psi[11:10];
        r_it  <= '0;
        r_run <= 1'b1;
      end else if (r_run) begin
        if (r_z[31]) begin
          r_x <= r_x + w_dx; r_y <= r_y - w_dy; r_z <= r_z + w_atan;
        end else begin
          r_x <= r_x - w_dx; r_y <= r_y + w_dy; r_z <= r_z - w_atan;
        end
        r_it <= r_it + 5'd1;
        if (r_it == c_last_it) begin
          r_run <= 1'b0;
          r_fin <= 1'b1;
        end
      end
      // Fold the first-quadrant result back to the full circle.
      if (r_fin) begin
        r_oen <= 1'b1;
        case (r_q)
          2'd0:    begin r_cos <= w_c;  r_sin <= w_s;  end
          2'd1:    begin r_cos <= -w_s; r_sin <= w_c;  end
          2'd2:    begin r_cos <= -w_c; r_sin <= -w_s; end
          default: begin r_cos <= w_s;  r_sin <= -w_c; end
        endcase
      end
    end
  end
endmodule

module inv_park_clark_tr (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_en,
  input  logic [11:0]        psi,
  input  logic signed [15:0] i_vd,
  input  logic signed [15:0] i_vq,
  output logic               o_busy,
  output logic               o_en,
  output logic signed [15:0] o_valpha,
  output logic signed [15:0] o_vbeta,
  output logic signed [15:0] o_va,
  output logic signed [15:0] o_vb,
  output logic signed [15:0] o_vc
);
  typedef enum logic [3:0] {
    S_IDLE, S_SC, S_M0, S_M1, S_M2, S_M3, S_AB, S_ABC, S_OUT
  } state_t;

  state_t             r_state;
  logic               r_sc_start, r_oen;
  logic [11:0]        r_psi;
  logic signed [15:0] r_vd, r_vq, r_sin, r_cos;
  logic signed [32:0] r_acc_a, r_acc_b;
  logic signed [15:0] r_valpha, r_vbeta, r_va, r_vb, r_vc;
  logic signed [15:0] r_o_alpha, r_o_beta, r_o_va, r_o_vb, r_o_vc;
  logic               w_sc_en;
  logic signed [15:0] w_sc_sin, w_sc_cos, w_mul_a, w_mul_b;
  logic signed [31:0] w_prod;
  logic signed [32:0] w_prod33, w_a13, w_b, w_vb_sum, w_vc_sum;

  function automatic logic signed [15:0] sat16(input logic signed [32:0] v);
    if (v > 33'sd32767)       sat16 = 16'sh7FFF;
    else if (v < -33'sd32768) sat16 = 16'sh8000;
    else                      sat16 = v[15:0];
  endfunction

  sincos u_sincos (
    .clk   (clk),
    .rstn  (~rst),
    .i_en  (r_sc_start),
    .i_psi (r_psi),
    .o_en  (w_sc_en),
    .o_sin (w_sc_sin),
    .o_cos (w_sc_cos)
  );

  always_comb begin
    w_mul_a = r_vd;
    w_mul_b = r_cos;
    case (r_state)
      S_M1:    begin w_mul_a = r_vq; w_mul_b = r_sin; end
      S_M2:    begin w_mul_a = r_vd; w_mul_b = r_sin; end
      S_M3:    begin w_mul_a = r_vq; w_mul_b = r_cos; end
      default: begin w_mul_a = r_vd; w_mul_b = r_cos; end
    endcase
  end

  assign w_prod   = 32'(w_mul_a) * 32'(w_mul_b);
  assign w_prod33 = 33'(w_prod);
  // 14189 / 16384 ~ sqrt(3)/2; valpha*8192 is the -1/2 term.
  assign w_a13    = 33'(r_valpha) <<< 13;
  assign w_b      = 33'(r_vbeta) * 33'sd14189;
  assign w_vb_sum = w_b - w_a13;
  assign w_vc_sum = -w_a13 - w_b;

  assign o_busy   = (r_state != S_IDLE);
  assign o_en     = r_oen;
  assign o_valpha = r_o_alpha;
  assign o_vbeta  = r_o_beta;
  assign o_va     = r_o_va;
  assign o_vb     = r_o_vb;
  assign o_vc     = r_o_vc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE; r_sc_start <= 1'b0; r_oen <= 1'b0;
      r_psi <= '0; r_vd <= '0; r_vq <= '0; r_sin <= '0; r_cos <= '0;
      r_acc_a <= '0; r_acc_b <= '0;
      r_valpha <= '0; r_vbeta <= '0; r_va <= '0; r_vb <= '0; r_vc <= '0;
      r_o_alpha <= '0; r_o_beta <= '0; r_o_va <= '0; r_o_vb <= '0; r_o_vc <= '0;
    end else begin
      r_sc_start <= 1'b0;
      r_oen      <= 1'b0;
      case (r_state)
        S_IDLE: if (i_en) begin
          r_psi      <= psi;
          r_vd       <= i_vd;
          r_vq       <= i_vq;
          r_sc_start <= 1'b1;
          r_state    <= S_SC;
        end
        S_SC: if (w_sc_en) begin
          r_sin   <= w_sc_sin;
          r_cos   <= w_sc_cos;
          r_state <= S_M0;
        end
        S_M0: begin r_acc_a <= w_prod33;           r_state <= S_M1; end
        S_M1: begin r_acc_a <= r_acc_a - w_prod33; r_state <= S_M2; end
        S_M2: begin r_acc_b <= w_prod33;           r_state <= S_M3; end
        S_M3: begin r_acc_b <= r_acc_b + w_prod33; r_state <= S_AB; end
        S_AB: begin
          r_valpha <= sat16(r_acc_a >>> 14);
          r_vbeta  <= sat16(r_acc_b >>> 14);
          r_state  <= S_ABC;
        end
        S_ABC: begin
          r_va    <= r_valpha;
          r_vb    <= sat16(w_vb_sum >>> 14);
          r_vc    <= sat16(w_vc_sum >>> 14);
          r_state <= S_OUT;
        end
        S_OUT: begin
          r_o_alpha <= r_valpha;
          r_o_beta  <= r_vbeta;
          r_o_va    <= r_va;
          r_o_vb    <= r_vb;
          r_o_vc    <= r_vc;
          r_oen     <= 1'b1;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_inv_park_clark_tr.sv
// ============================================================================
//  Module      : tb_inv_park_clark_tr
//  Description : Scoreboard bench for inv_park_clark_tr against a real-valued
//                sin/cos reference and round-trip Clarke/Park recovery.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_inv_park_clark_tr;
  logic               clk = 1'b0;
  logic               rst, i_en;
  logic [11:0]        psi;
  logic signed [15:0] i_vd, i_vq;
  logic               o_busy, o_en;
  logic signed [15:0] o_valpha, o_vbeta, o_va, o_vb, o_vc;

  inv_park_clark_tr dut (
    .clk(clk), .rst(rst), .i_en(i_en), .psi(psi), .i_vd(i_vd), .i_vq(i_vq),
    .o_busy(o_busy), .o_en(o_en), .o_valpha(o_valpha), .o_vbeta(o_vbeta),
    .o_va(o_va), .o_vb(o_vb), .o_vc(o_vc)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit rt;
    int p, vd, vq;
    int al, be, a, b, c;
  } exp_t;

  exp_t sb[$];
  int   total = 0, bad = 0;
  int   cyc = 0, sc_edge = -100;
  exp_t m_e;

  always @(posedge clk) cyc++;

  function automatic int rnd_sc(int p, bit is_sin);
    real a, v;
    a = 6.283185307179586 * p / 4096.0;
    v = is_sin ? $sin(a) : $cos(a);
    return $rtoi($floor(16384.0 * v + 0.5));
  endfunction

  // Angles whose scaled sin/cos lie near a rounding tie are left to the sweep.
  function automatic bit near_half(int p);
    real a, s, c;
    a = 6.283185307179586 * p / 4096.0;
    s = 16384.0 * $sin(a); c = 16384.0 * $cos(a);
    s = s - $floor(s); c = c - $floor(c);
    return (s > 0.48 && s < 0.52) || (c > 0.48 && c < 0.52);
  endfunction

  function automatic int sat16(longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return int'(v);
  endfunction

  function automatic exp_t model(int p, int vd, int vq);
    exp_t e;
    longint s, c, t1, t2;
    s = rnd_sc(p, 1'b1);
    c = rnd_sc(p, 1'b0);
    e.rt = 1'b0; e.p = p; e.vd = vd; e.vq = vq;
    e.al = sat16((longint'(vd) * c - longint'(vq) * s) >>> 14);
    e.be = sat16((longint'(vd) * s + longint'(vq) * c) >>> 14);
    t1 = -longint'(e.al) * 8192;
    t2 = longint'(e.be) * 14189;
    e.a = e.al;
    e.b = sat16((t1 + t2) >>> 14);
    e.c = sat16((t1 - t2) >>> 14);
    return e;
  endfunction

  function automatic exp_t mk_const(int al, int be, int a, int b, int c);
    exp_t e;
    e.rt = 1'b0; e.p = 0; e.vd = 0; e.vq = 0;
    e.al = al; e.be = be; e.a = a; e.b = b; e.c = c;
    return e;
  endfunction

  function automatic exp_t mk_rt(int p, int vd, int vq);
    exp_t e;
    e = mk_const(0, 0, 0, 0, 0);
    e.rt = 1'b1; e.p = p; e.vd = vd; e.vq = vq;
    return e;
  endfunction

  task automatic chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_tol(string name, int act, int exp, int tol);
    total++;
    if (act > exp + tol || act < exp - tol) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d +/- %0d (t=%0t)", name, act, exp, tol, $time);
    end
  endtask

  task automatic check_rt(exp_t e);
    real a, s, c, al, be, d, q;
    a  = 6.283185307179586 * e.p / 4096.0;
    s  = $sin(a); c = $cos(a);
    al = (2.0 * o_va - o_vb - o_vc) / 3.0;
    be = (o_vb - o_vc) / $sqrt(3.0);
    d  = al * c + be * s;
    q  = -al * s + be * c;
    chk_tol("rt_vd", $rtoi($floor(d + 0.5)), e.vd, 8);
    chk_tol("rt_vq", $rtoi($floor(q + 0.5)), e.vq, 8);
    chk_tol("abc_sum", int'(o_va) + int'(o_vb) + int'(o_vc), 0, 2);
  endtask

  // Monitor: every o_en pops one expectation.
  always @(negedge clk) begin
    if (!rst && dut.u_sincos.o_en) sc_edge = cyc + 1;
    if (!rst && o_en) begin
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_o_en: got o_en=1, expected no pending request (t=%0t)", $time);
      end else begin
        m_e = sb.pop_front();
        chk("latency", cyc - sc_edge, 7);
        if (m_e.rt) check_rt(m_e);
        else begin
          chk("valpha", o_valpha, m_e.al);
          chk("vbeta", o_vbeta, m_e.be);
          chk("va", o_va, m_e.a);
          chk("vb", o_vb, m_e.b);
          chk("vc", o_vc, m_e.c);
        end
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (o_busy && n < 500) begin @(negedge clk); n++; end
    if (n >= 500) begin
      total++; bad++;
      $display("FAIL idle_timeout: got busy after %0d cycles, expected idle", n);
    end
  endtask

  task automatic wait_sc();
    int n = 0;
    while (!dut.u_sincos.o_en && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) begin
      total++; bad++;
      $display("FAIL sincos_timeout: got no sincos o_en, expected one within 200 cycles");
    end
  endtask

  task automatic scramble();
    psi = 12'($urandom); i_vd = 16'($urandom); i_vq = 16'($urandom);
  endtask

  task automatic issue(int p, int vd, int vq, exp_t e);
    wait_idle();
    psi = 12'(p); i_vd = 16'(vd); i_vq = 16'(vq); i_en = 1'b1;
    sb.push_back(e);
    @(negedge clk);
    i_en = 1'b0;
    scramble();
  endtask

  task automatic rand_req(output int p, output int vd, output int vq);
    logic signed [15:0] r16;
    do p = $urandom_range(0, 4095); while (near_half(p));
    r16 = 16'($urandom); vd = int'(r16);
    r16 = 16'($urandom); vq = int'(r16);
  endtask

  int p, vd, vq, n;

  initial begin
    rst = 1'b1; i_en = 1'b0; psi = '0; i_vd = '0; i_vq = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", o_busy, 0);
    chk("rst_o_en", o_en, 0);
    chk("rst_valpha", o_valpha, 0);
    chk("rst_vbeta", o_vbeta, 0);
    chk("rst_va", o_va, 0);
    chk("rst_vb", o_vb, 0);
    chk("rst_vc", o_vc, 0);
    rst = 1'b0;
    @(negedge clk);

    issue(0, 8192, 0, mk_const(8192, 0, 8192, -4096, -4096));
    issue(1024, 8192, 0, mk_const(0, 8192, 0, 7094, -7095));
    issue(512, 32767, 32767, mk_const(0, 32767, 0, 28377, -28378));
    issue(4095 + 1, 8192, 0, mk_const(8192, 0, 8192, -4096, -4096));

    for (int k = 0; k < 30; k++) begin
      rand_req(p, vd, vq);
      issue(p, vd, vq, model(p, vd, vq));
    end

    // Second strobe two cycles after the first must be ignored.
    rand_req(p, vd, vq);
    issue(p, vd, vq, model(p, vd, vq));
    @(negedge clk);
    chk("busy_during_op", o_busy, 1);
    rand_req(p, vd, vq);
    psi = 12'(p); i_vd = 16'(vd); i_vq = 16'(vq); i_en = 1'b1;
    @(negedge clk);
    i_en = 1'b0;
    scramble();

    // Strobe held across OUT and the first IDLE cycle: only the latter counts.
    rand_req(p, vd, vq);
    issue(p, vd, vq, model(p, vd, vq));
    wait_sc();
    repeat (7) @(negedge clk);
    chk("busy_in_out", o_busy, 1);
    rand_req(p, vd, vq);
    psi = 12'(p); i_vd = 16'(vd); i_vq = 16'(vq); i_en = 1'b1;
    @(negedge clk);
    chk("o_en_after_out", o_en, 1);
    sb.push_back(model(p, vd, vq));
    @(negedge clk);
    i_en = 1'b0;
    scramble();

    // Reset while in M2 aborts the request.
    rand_req(p, vd, vq);
    issue(p, vd, vq, model(p, vd, vq));
    wait_sc();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    void'(sb.pop_back());
    #1;
    chk("abort_busy", o_busy, 0);
    chk("abort_o_en", o_en, 0);
    chk("abort_valpha", o_valpha, 0);
    chk("abort_vbeta", o_vbeta, 0);
    chk("abort_va", o_va, 0);
    chk("abort_vb", o_vb, 0);
    chk("abort_vc", o_vc, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rand_req(p, vd, vq);
    issue(p, vd, vq, model(p, vd, vq));

    for (int k = 0; k < 4096; k += 10)
      issue(k, 8192, 4096, mk_rt(k, 8192, 4096));

    n = 0;
    while (sb.size() != 0 && n < 2000) begin @(negedge clk); n++; end
    chk("drain", sb.size(), 0);
    repeat (60) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

`default_nettype wire
